// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared types and helpers for the sequential shift-add multiplier.
//   - state_t   : controller states (IDLE, BUSY, DONE)
//   - cnt_width : width of the step counter for a given operand width
// Build option: MULT_SIGNED_EN selects two's complement arithmetic
// (see mult_step); nothing in this package depends on it.
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step counter runs 0..width-1, so $clog2(width) bits suffice (width >= 2).
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage : mult_pkg

// File: rtl/mult_step.sv
// -----------------------------------------------------------------------------
// mult_step
//   One combinational shift-add iteration of the multiplier.
//   Ports:
//     acc_i    [2*WIDTH-1:0]  accumulator before the step
//     mcand_i  [WIDTH-1:0]    multiplicand
//     bit_i                   current multiplier bit
//     last_i                  this is step WIDTH-1 (multiplier MSB)
//     acc_o    [2*WIDTH-1:0]  accumulator after add/subtract and shift
// Build option: MULT_SIGNED_EN -> two's complement operands; the upper slice
// is sign-extended and the MSB step subtracts the multiplicand.
// -----------------------------------------------------------------------------
module mult_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic               bit_i,
   input  logic               last_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0] addend;
   logic [WIDTH:0] upper;

   // NOTE: every variable written here gets a value on every path (defaults
   // first), otherwise synthesis infers a latch.
   always_comb begin
      addend = '0;
      upper  = '0;
`ifdef MULT_SIGNED_EN
      if (bit_i) addend = {mcand_i[WIDTH-1], mcand_i};
      // The multiplier MSB carries weight -2^(WIDTH-1), hence the subtraction.
      if (last_i) upper = {acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]} - addend;
      else        upper = {acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]} + addend;
`else
      if (bit_i) addend = {1'b0, mcand_i};
      upper = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
`endif
   end

   // Shift the (2*WIDTH+1)-bit {upper, lower} right by one; the LSB of the
   // old lower half is finished and drops out of the window.
   assign acc_o = {upper, acc_i[WIDTH-1:1]};

   // acc_i[0] is shifted out; last_i only matters for signed arithmetic.
   logic unused_ok;
   assign unused_ok = ^{acc_i[0], last_i};

endmodule : mult_step

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//   Sequential shift-add multiplier: one partial product per clock, WIDTH
//   steps per operation, valid/ready on both sides, no overlapped issue.
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   operands valid          in_ready   accepting (IDLE only)
//     inp1       multiplicand [WIDTH]    inp2       multiplier [WIDTH]
//     out_valid  product valid (DONE)    out_ready  consumer accepts
//     product    result [2*WIDTH], holds its value after the handshake
// Build option: MULT_SIGNED_EN -> two's complement operands and product.
// -----------------------------------------------------------------------------
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   inp1,
   input  logic [WIDTH-1:0]   inp2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               last_step;
   logic [2*WIDTH-1:0] step_acc;

   assign last_step = (cnt_q == LAST_STEP);

   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .bit_i   (mplier_q[cnt_q]),
      .last_i  (last_step),
      .acc_o   (step_acc)
   );

   // ---- FSM: state register -------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---- FSM: next state -----------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- FSM: outputs --------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   assign product = product_q;

   // ---- Datapath next state -------------------------------------------------
   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = inp1;
               mplier_d = inp2;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         BUSY: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            // Product gets its own register so it survives the next accept.
            if (last_step) product_d = step_acc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

endmodule : seq_shift_add_mult

// File: tb/tb_seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mult
//   Directed bench: a WIDTH=4 and a WIDTH=8 instance on a shared clock/reset.
//   Expected products are hand-computed for both unsigned and MULT_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mult;

`ifdef MULT_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  inp1_4, inp2_4;
   logic [7:0]  product4;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  inp1_8, inp2_8;
   logic [15:0] product8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_shift_add_mult #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .inp1      (inp1_4),
      .inp2      (inp2_4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .product   (product4)
   );

   seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .inp1      (inp1_8),
      .inp2      (inp2_8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .product   (product8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One WIDTH=4 operation. early_rdy raises out_ready before issue (must be
   // ignored outside DONE); hold keeps out_ready low for that many cycles
   // in DONE while offering new operands that must not be taken.
   task automatic mul4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input logic early_rdy, input int hold);
      int lat;
      @(negedge clk);
      check({tag, "/in_ready_idle"}, 32'(in_ready4), 32'd1);
      out_ready4 = early_rdy;
      inp1_4     = a;
      inp2_4     = b;
      in_valid4  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      check({tag, "/in_ready_busy"}, 32'(in_ready4), 32'd0);
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'd4);
      check({tag, "/product"}, 32'(product4), 32'(exp));
      out_ready4 = 1'b0;
      for (int i = 0; i < hold; i++) begin
         in_valid4 = 1'b1;
         inp1_4    = 4'h3;
         inp2_4    = 4'h3;
         @(negedge clk);
         check({tag, "/hold_valid"}, 32'(out_valid4), 32'd1);
         check({tag, "/hold_product"}, 32'(product4), 32'(exp));
         check({tag, "/hold_in_ready"}, 32'(in_ready4), 32'd0);
      end
      in_valid4  = 1'b0;
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      check({tag, "/post_valid"}, 32'(out_valid4), 32'd0);
      check({tag, "/post_in_ready"}, 32'(in_ready4), 32'd1);
      check({tag, "/post_product"}, 32'(product4), 32'(exp));
   endtask

   task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
      int lat;
      @(negedge clk);
      inp1_8    = a;
      inp2_8    = b;
      in_valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'd8);
      check({tag, "/product"}, 32'(product8), 32'(exp));
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      check({tag, "/post_valid"}, 32'(out_valid8), 32'd0);
   endtask

   typedef struct {
      string      tag;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp_u;
      logic [7:0] exp_s;
   } vec4_t;

   vec4_t vec4 [8] = '{
      '{"13x12",  4'd13, 4'd12, 8'h9C, 8'h0C},
      '{"15x15",  4'd15, 4'd15, 8'hE1, 8'h01},
      '{"0x15",   4'd0,  4'd15, 8'h00, 8'h00},
      '{"15x0",   4'd15, 4'd0,  8'h00, 8'h00},
      '{"Dx5",    4'hD,  4'h5,  8'h41, 8'hF1},
      '{"8x8",    4'h8,  4'h8,  8'h40, 8'h40},
      '{"7x7",    4'h7,  4'h7,  8'h31, 8'h31},
      '{"1x15",   4'h1,  4'hF,  8'h0F, 8'hFF}
   };

   initial begin
      int seen;
      rst_n      = 1'b0;
      in_valid4  = 1'b0;
      out_ready4 = 1'b0;
      inp1_4     = '0;
      inp2_4     = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b0;
      inp1_8     = '0;
      inp2_8     = '0;

      #1;
      check("reset/in_ready", 32'(in_ready4), 32'd1);
      check("reset/out_valid", 32'(out_valid4), 32'd0);
      check("reset/product", 32'(product4), 32'd0);
      check("reset/product8", 32'(product8), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic op with out_ready already high (ignored until DONE).
      mul4("10x12", 4'd10, 4'd12, SGN ? 8'h18 : 8'h78, 1'b1, 0);

      // Back-to-back and boundary vectors.
      foreach (vec4[i])
         mul4(vec4[i].tag, vec4[i].a, vec4[i].b,
              SGN ? vec4[i].exp_s : vec4[i].exp_u, 1'b0, 0);

      // Consumer stalls 5 cycles; new operands offered during the stall.
      mul4("hold", 4'd10, 4'd12, SGN ? 8'h18 : 8'h78, 1'b0, 5);

      // Reset two cycles after accept: result must be discarded.
      @(negedge clk);
      inp1_4    = 4'd10;
      inp2_4    = 4'd12;
      in_valid4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst/out_valid", 32'(out_valid4), 32'd0);
      check("midrst/product", 32'(product4), 32'd0);
      check("midrst/in_ready", 32'(in_ready4), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid4) seen++;
      end
      check("midrst/no_stale_valid", 32'(seen), 32'd0);
      check("midrst/product_after", 32'(product4), 32'd0);

      // Function restored after reset.
      mul4("after_rst", 4'd6, 4'd7, 8'h2A, 1'b0, 0);

      // WIDTH=8 instance.
      mul8("w8_255x255", 8'd255, 8'd255, SGN ? 16'h0001 : 16'hFE01);
      mul8("w8_200x3",   8'd200, 8'd3,   SGN ? 16'hFF58 : 16'h0258);
      mul8("w8_128x128", 8'd128, 8'd128, 16'h4000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_shift_add_mult
